// File: rtl/ccip_rd_arb_pkg.sv
// Shared types and width helpers for the CCI-P c0 read-request arbiter.
// Optional feature macro used by the top: CCIP_RD_ARB_PERF_EN.
package ccip_rd_arb_pkg;

  // Requester-ID width. A minimum of one bit keeps slices legal.
  function automatic int calc_id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // The requester-private tag fills the rest of the 16-bit mdata field.
  function automatic int calc_tag_w(input int num_req);
    return 16 - calc_id_w(num_req);
  endfunction

  // Each counter must be able to hold MAX_OUTSTANDING itself.
  function automatic int calc_cnt_w(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

  localparam int DEF_NUM_REQ         = 4;
  localparam int DEF_MAX_OUTSTANDING = 64;
  localparam int DEF_ID_W            = calc_id_w(DEF_NUM_REQ);
  localparam int DEF_TAG_W           = calc_tag_w(DEF_NUM_REQ);
  localparam int DEF_CNT_W           = calc_cnt_w(DEF_MAX_OUTSTANDING);

  // mdata layout on the c0 channel: requester ID in the top bits.
  typedef struct packed {
    logic [DEF_ID_W-1:0]  id;
    logic [DEF_TAG_W-1:0] tag;
  } t_rd_mdata;

  typedef logic [DEF_CNT_W-1:0] t_outstanding_cnt;

endpackage

// File: rtl/ccip_rd_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting index after
// last_grant_i, wrapping modulo N. Shared by the read and write channels.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_valid_o
);

  // Scan N positions starting one past the previous winner.
  always_comb begin
    int idx;
    logic found;
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    found         = 1'b0;
    idx           = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant_i) + k) % N;
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        grant_o[idx]  = 1'b1;
        grant_idx_o   = IDX_W'(idx);
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccip_rd_arbiter.sv
// Shares the CCI-P c0 read-request channel among NUM_REQ requesters.
// Round-robin grant, almfull throttling, per-requester in-flight caps,
// requester ID carried in mdata and used to route responses back.
// Optional macro CCIP_RD_ARB_PERF_EN adds grant and almfull-stall counters.
//
// Handshake: a request transfers in the cycle where req_valid[i] and
// req_ready[i] are both high; req_ready never depends on anything but
// req_valid, the counters, almfull and the RR pointer. resp_valid is a
// one-cycle strobe with no backpressure.
module ccip_rd_arbiter
  import ccip_rd_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int ID_W            = calc_id_w(NUM_REQ),
  parameter int TAG_W           = 16 - ID_W,
  parameter int ADDR_W          = 42,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      c0tx_valid,
  output logic [ADDR_W-1:0]         c0tx_addr,
  output logic [15:0]               c0tx_mdata,
  input  logic                      c0tx_almfull,
  input  logic                      c0rx_valid,
  input  logic [15:0]               c0rx_mdata,
  input  logic [511:0]              c0rx_data,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [TAG_W-1:0]          resp_tag,
  output logic [511:0]              resp_data,
`ifdef CCIP_RD_ARB_PERF_EN
  output logic [NUM_REQ*32-1:0]     perf_grants,
  output logic [31:0]               perf_almfull_stall,
`endif
  output logic                      outstanding_any,
  output logic                      err_unexpected
);

  localparam int CNT_W = calc_cnt_w(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]   cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   cnt_d [NUM_REQ];
  logic [ID_W-1:0]    last_grant_q;
  logic               c0tx_valid_q;
  logic [ADDR_W-1:0]  c0tx_addr_q;
  logic [15:0]        c0tx_mdata_q;
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [NUM_REQ-1:0] resp_valid_d;
  logic [TAG_W-1:0]   resp_tag_q;
  logic [511:0]       resp_data_q;
  logic               err_q;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_valid;

  logic [ID_W-1:0]    rsp_id;
  logic               rsp_id_in_range;
  logic               rsp_accept;

  // A requester may compete only while below its cap and the shim has room.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (cnt_q[i] < MAX_CNT) && !c0tx_almfull;
    end
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req_i         (eligible),
    .last_grant_i  (last_grant_q),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  assign req_ready = grant;

  assign rsp_id = c0rx_mdata[15 -: ID_W];

  // Only non-power-of-two NUM_REQ can produce an out-of-range ID.
  if ((1 << ID_W) > NUM_REQ) begin : g_id_chk
    assign rsp_id_in_range = (32'(rsp_id) < NUM_REQ);
  end else begin : g_id_all
    assign rsp_id_in_range = 1'b1;
  end

  // A response is accepted only if it maps to a requester with reads in flight.
  assign rsp_accept = c0rx_valid && rsp_id_in_range && (cnt_q[rsp_id] != '0);

  // Per-requester counter next state; simultaneous grant and response cancel.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      logic inc;
      logic dec;
      inc = grant_valid && (grant_idx == ID_W'(i));
      dec = rsp_accept && (rsp_id == ID_W'(i));
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec && !inc) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // Response strobe is steered to the requester named in mdata.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid_d[i] = c0rx_valid && (rsp_id == ID_W'(i));
    end
  end

  // Issue registers, RR pointer and outstanding counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      c0tx_valid_q <= 1'b0;
      c0tx_addr_q  <= '0;
      c0tx_mdata_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      if (grant_valid) begin
        last_grant_q <= grant_idx;
        c0tx_valid_q <= 1'b1;
        c0tx_addr_q  <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
        c0tx_mdata_q <= {grant_idx, req_tag[int'(grant_idx)*TAG_W +: TAG_W]};
      end else begin
        c0tx_valid_q <= 1'b0;
      end
    end
  end

  // Registered response path and sticky protocol error.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= '0;
      resp_tag_q   <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_tag_q   <= c0rx_mdata[TAG_W-1:0];
      resp_data_q  <= c0rx_data;
      if (c0rx_valid && !rsp_accept) begin
        err_q <= 1'b1;
      end
    end
  end

  // Any requester with reads in flight.
  always_comb begin
    outstanding_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cnt_q[i] != '0) begin
        outstanding_any = 1'b1;
      end
    end
  end

  assign c0tx_valid     = c0tx_valid_q;
  assign c0tx_addr      = c0tx_addr_q;
  assign c0tx_mdata     = c0tx_mdata_q;
  assign resp_valid     = resp_valid_q;
  assign resp_tag       = resp_tag_q;
  assign resp_data      = resp_data_q;
  assign err_unexpected = err_q;

`ifdef CCIP_RD_ARB_PERF_EN
  logic [31:0] perf_grants_q [NUM_REQ];
  logic [31:0] perf_stall_q;

  // Saturating grant and almfull-stall counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        perf_grants_q[i] <= '0;
      end
    end else begin
      if ((|req_valid) && c0tx_almfull && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (perf_grants_q[i] != '1)) begin
          perf_grants_q[i] <= perf_grants_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      perf_grants[i*32 +: 32] = perf_grants_q[i];
    end
  end

  assign perf_almfull_stall = perf_stall_q;
`endif

endmodule
